// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset release sequencer.
// Holds the sequencer state enum and default parameter values.
// Helper max2() is used to size counters from parameters.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGGER     = 4;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asynchronous assert, synchronous deassert of r.
// Latency: deassertion reaches r_sync SYNC_STAGES ck edges after r falls.
// Ports: ck clock, r async active-high reset, r_sync synchronized reset (active-high).
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic ck,
  input  logic r,
  output logic r_sync
);

  logic [SYNC_STAGES-1:0] chain;

  // Zeros shift in from the bottom once r is low; any r high refills the chain.
  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign r_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Staggered reset release sequencer for NUM_DOMAINS downstream reset domains.
// Latency: after sync release, HOLD_CYCLES edges all-held, then one domain per STAGGER edges.
// Ports: ck, r (async high), srst_req/srst_ack soft reset handshake, rn_out per-domain active-low reset, done.
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   ck,
  input  logic                   r,
  input  logic                   srst_req,
  output logic                   srst_ack,
  output logic [NUM_DOMAINS-1:0] rn_out,
  output logic                   done
);

  localparam int CW = $clog2(max2(HOLD_CYCLES, STAGGER) + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  logic r_sync;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rn_q, rn_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .ck     (ck),
    .r      (r),
    .r_sync (r_sync)
  );

  // All outputs are registered: next values computed here, captured below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rn_d    = rn_q;
    done_d  = done_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        rn_d   = '0;
        done_d = 1'b0;
        if (!r_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rn_d  = NUM_DOMAINS'(1);
          idx_d = IW'(1);
          cnt_d = '0;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // idx_q is the next domain to release; lower domains are already out.
        if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IW'(i)) begin
              rn_d[i] = 1'b1;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_ASSERT;
        rn_d    = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Soft reset overrides the sequence everywhere except while still in ASSERT.
    if (srst_req && (state_q != ST_ASSERT)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rn_d    = '0;
      done_d  = 1'b0;
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rn_q    <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rn_q    <= rn_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign rn_out   = rn_q;
  assign done     = done_q;
  assign srst_ack = ack_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Bench for rst_release_seq: default instance plus a 1/1/1 edge-parameter instance.
// Expected outputs come from a timeline model: domain i is released HOLD + i*STAGGER edges after the hold start.
// Inputs driven on the falling edge, outputs compared on the falling edge.
module tb_rst_release_seq;

  localparam int SYNC = 2;
  localparam int NA = 4, HA = 16, SA = 4;
  localparam int NB = 1, HB = 1,  SB = 1;

  logic ck = 1'b0;
  logic r  = 1'b1;
  logic srst_a = 1'b0, srst_b = 1'b0;
  logic ack_a, ack_b, done_a, done_b;
  logic [NA-1:0] rn_a;
  logic [NB-1:0] rn_b;

  int checks = 0;
  int failures = 0;

  // Model state: k = edges since r fell, hs = edge that (re)started HOLD (0 = not yet).
  int  k = 0;
  int  hs_a = 0, hs_b = 0;
  bit  eack_a = 0, eack_b = 0;

  always #5 ck = ~ck;

  rst_release_seq u_dut_a (
    .ck(ck), .r(r), .srst_req(srst_a), .srst_ack(ack_a), .rn_out(rn_a), .done(done_a)
  );

  rst_release_seq #(
    .NUM_DOMAINS(NB), .HOLD_CYCLES(HB), .STAGGER(SB), .SYNC_STAGES(SYNC)
  ) u_dut_b (
    .ck(ck), .r(r), .srst_req(srst_b), .srst_ack(ack_b), .rn_out(rn_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rn(input int kk, input int hs, input int n,
                                         input int h, input int s);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (hs > 0 && kk >= hs + h + i * s) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic compare_all();
    logic [15:0] ea, eb;
    ea = exp_rn(k, hs_a, NA, HA, SA);
    eb = exp_rn(k, hs_b, NB, HB, SB);
    check("a_rn",   32'(rn_a),   32'(ea[NA-1:0]));
    check("a_done", 32'(done_a), 32'(ea[NA-1:0] == {NA{1'b1}}));
    check("a_ack",  32'(ack_a),  32'(eack_a));
    check("b_rn",   32'(rn_b),   32'(eb[NB-1:0]));
    check("b_done", 32'(done_b), 32'(eb[NB-1:0] == {NB{1'b1}}));
    check("b_ack",  32'(ack_b),  32'(eack_b));
  endtask

  // One ck cycle: apply requests, advance the model at the edge, compare after it.
  task automatic step(input bit sa, input bit sb);
    srst_a = sa;
    srst_b = sb;
    @(posedge ck);
    k++;
    eack_a = 0;
    eack_b = 0;
    if (k == SYNC + 1) begin
      hs_a = k;
      hs_b = k;
    end else if (k > SYNC + 1) begin
      if (sa) begin hs_a = k; eack_a = 1; end
      if (sb) begin hs_b = k; eack_b = 1; end
    end
    @(negedge ck);
    compare_all();
    srst_a = 1'b0;
    srst_b = 1'b0;
  endtask

  // Short r pulse inside one low phase; outputs must clear with no ck edge.
  task automatic async_pulse();
    #1 r = 1'b1;
    #1;
    check("async_rn_a",   32'(rn_a),   32'd0);
    check("async_done_a", 32'(done_a), 32'd0);
    check("async_ack_a",  32'(ack_a),  32'd0);
    check("async_rn_b",   32'(rn_b),   32'd0);
    check("async_done_b", 32'(done_b), 32'd0);
    #1 r = 1'b0;
    k = 0; hs_a = 0; hs_b = 0; eack_a = 0; eack_b = 0;
  endtask

  initial begin
    int burst;
    burst = 0;
    repeat (3) @(negedge ck);
    compare_all();                       // reset state
    r = 1'b0;

    // Power-on timeline; instance b gets requests while still in ASSERT.
    for (int i = 0; i < 40; i++) step(1'b0, (k + 1) <= SYNC + 1);

    // One-cycle soft reset in RUN.
    step(1'b1, 1'b1);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0);

    // Async reset between edges 25 and 26.
    @(negedge ck);
    async_pulse();
    while (k < 25) step(1'b0, 1'b0);
    async_pulse();

    // Soft reset mid-release at edge 24.
    for (int i = 0; i < 60; i++) step((k + 1) == 24, 1'b0);

    // Held request for 5 edges.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);

    // Random traffic with bursts and occasional async resets.
    for (int i = 0; i < 400; i++) begin
      bit sa, sb;
      if ($urandom_range(0, 149) == 0) begin
        async_pulse();
      end
      if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 6);
      sa = (burst > 0);
      if (burst > 0) burst--;
      sb = ($urandom_range(0, 9) == 0);
      step(sa, sb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
